// File: rtl/eq2_pkg.sv
// eq2_pkg: types, constants and the derivative helper shared by the eq2
// activation, its backward unit eq2_grad and any eq2 checkers.
//   WIDTH / DW   : base width and data width (DW = 2*WIDTH)
//   act_t        : signed activation/gradient word
//   ACT_MAX/MIN  : saturation limits of act_t
//   deriv_t      : derivative code in {-1, 0, +1}
//   eq2_deriv()  : f'(X) for f(X) = max(|X|, 1), subgradient 0 at the kinks
package eq2_pkg;

  localparam int WIDTH = 9;
  localparam int DW    = 2 * WIDTH;

  typedef logic signed [DW-1:0] act_t;

  localparam act_t ACT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam act_t ACT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef logic signed [1:0] deriv_t;

  localparam deriv_t D_POS  = 2'sb01;
  localparam deriv_t D_ZERO = 2'sb00;
  localparam deriv_t D_NEG  = 2'sb11;

  // Valid flag of the output register.
  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_t;

  // f(X) is flat (=1) on [-1, 1]; the kinks at +-1 take subgradient 0.
  function automatic deriv_t eq2_deriv(input act_t x);
    deriv_t d;
    if (x >= act_t'(3'sd2)) begin
      d = D_POS;
    end else if (x <= act_t'(-3'sd2)) begin
      d = D_NEG;
    end else begin
      d = D_ZERO;
    end
    return d;
  endfunction

endpackage

// File: rtl/eq2_grad_if.sv
// eq2_grad_if: forward-capture, backward-gradient and output-gradient
// handshakes of eq2_grad, plus the stack occupancy.
//   master : the surrounding datapath (drives fwd/bwd payloads, grad_ready)
//   slave  : eq2_grad itself
interface eq2_grad_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 fwd_valid;
  logic                 fwd_ready;
  logic signed [DW-1:0] fwd_x;
  logic                 bwd_valid;
  logic                 bwd_ready;
  logic signed [DW-1:0] bwd_g;
  logic                 grad_valid;
  logic                 grad_ready;
  logic signed [DW-1:0] grad_out;
  logic [CW-1:0]        count;

  modport master (
    output fwd_valid, fwd_x, bwd_valid, bwd_g, grad_ready,
    input  fwd_ready, bwd_ready, grad_valid, grad_out, count
  );

  modport slave (
    input  fwd_valid, fwd_x, bwd_valid, bwd_g, grad_ready,
    output fwd_ready, bwd_ready, grad_valid, grad_out, count
  );

endinterface

// File: rtl/eq2_lifo.sv
// eq2_lifo: DEPTH x DW register stack holding forward activations.
//   clk, rst   : clock, synchronous active-high reset (count only)
//   flush      : synchronous clear of count; push/pop in that cycle ignored
//   push/wr_data : write wr_data on top
//   pop/rd_data  : rd_data is always the current top entry
//   count      : number of stored entries (0..DEPTH)
// Push and pop together replace the top entry in place; count holds.
module eq2_lifo #(
  parameter int WORD_W = 18,
  parameter int DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WORD_W-1:0]            wr_data,
  output logic [WORD_W-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] stack_r [DEPTH];
  logic [AW:0]       count_r;
  logic [AW-1:0]     top_idx_s;
  logic [AW-1:0]     wr_idx_s;
  logic              do_push_s;
  logic              do_pop_s;

  // Address decode: a simultaneous pop frees the top slot, so the push reuses it.
  always_comb begin
    do_push_s = push && !flush && !rst;
    do_pop_s  = pop  && !flush && !rst;
    top_idx_s = count_r[AW-1:0] - AW'(1'b1);
    if (do_pop_s) begin
      wr_idx_s = top_idx_s;
    end else begin
      wr_idx_s = count_r[AW-1:0];
    end
  end

  // Stack storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      stack_r[wr_idx_s] <= wr_data;
    end
  end

  // Occupancy counter: the only control state of the stack.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_r <= '0;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = stack_r[top_idx_s];
  assign count   = count_r;

endmodule

// File: rtl/eq2_grad.sv
// eq2_grad: backward pass of eq2. Forward activations are pushed onto a
// LIFO; each upstream gradient pops the matching X and produces
// grad = g * f'(X) in a registered output with valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   flush    : clears the stack; a pending output is still delivered
//   bus      : eq2_grad_if slave (fwd_*, bwd_*, grad_*, count)
// WIDTH must equal eq2_pkg::WIDTH so the shared derivative helper applies.
module eq2_grad
  import eq2_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  eq2_grad_if.slave bus
);

  localparam int DWL = 2 * WIDTH;
  localparam int CW  = $clog2(DEPTH) + 1;

  localparam logic signed [DWL-1:0] G_MAX = {1'b0, {(DWL-1){1'b1}}};
  localparam logic signed [DWL-1:0] G_MIN = {1'b1, {(DWL-1){1'b0}}};

  out_state_t           state_r;
  out_state_t           state_nxt_s;
  logic signed [DWL-1:0] grad_out_r;
  logic signed [DWL-1:0] grad_calc_s;
  logic [DWL-1:0]       top_x_s;
  logic [CW-1:0]        count_s;
  deriv_t               deriv_s;
  logic                 fwd_ready_s;
  logic                 bwd_ready_s;
  logic                 push_s;
  logic                 pop_s;

  eq2_lifo #(
    .WORD_W (DWL),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (bus.fwd_x),
    .rd_data (top_x_s),
    .count   (count_s)
  );

  // Readies depend only on registered state and grad_ready; transfers are masked by flush.
  always_comb begin
    fwd_ready_s = (count_s != CW'(DEPTH));
    bwd_ready_s = (count_s != '0) && ((state_r == OUT_IDLE) || bus.grad_ready);
    push_s      = bus.fwd_valid && fwd_ready_s && !flush;
    pop_s       = bus.bwd_valid && bwd_ready_s && !flush;
  end

  // Mask / negate datapath; -MIN saturates to MAX.
  always_comb begin
    deriv_s = eq2_deriv(act_t'(top_x_s));
    case (deriv_s)
      D_POS: grad_calc_s = bus.bwd_g;
      D_NEG: begin
        if (bus.bwd_g == G_MIN) begin
          grad_calc_s = G_MAX;
        end else begin
          grad_calc_s = -bus.bwd_g;
        end
      end
      default: grad_calc_s = '0;
    endcase
  end

  // Output valid next-state: a pop always (re)loads, otherwise grad_ready drains.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      OUT_IDLE: begin
        if (pop_s) begin
          state_nxt_s = OUT_HOLD;
        end else begin
          state_nxt_s = OUT_IDLE;
        end
      end
      OUT_HOLD: begin
        if (pop_s) begin
          state_nxt_s = OUT_HOLD;
        end else if (bus.grad_ready) begin
          state_nxt_s = OUT_IDLE;
        end else begin
          state_nxt_s = OUT_HOLD;
        end
      end
      default: state_nxt_s = OUT_IDLE;
    endcase
  end

  // Output valid state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= OUT_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output data register; loads only on a pop so it is stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      grad_out_r <= '0;
    end else if (pop_s) begin
      grad_out_r <= grad_calc_s;
    end else begin
      grad_out_r <= grad_out_r;
    end
  end

  assign bus.fwd_ready  = fwd_ready_s;
  assign bus.bwd_ready  = bwd_ready_s;
  assign bus.grad_valid = (state_r == OUT_HOLD);
  assign bus.grad_out   = grad_out_r;
  assign bus.count      = count_s;

endmodule

// File: tb/tb_eq2_grad.sv
// tb_eq2_grad: directed bench for eq2_grad with a queue-based stack model
// checked every cycle, plus literal expectations at key points.
module tb_eq2_grad;

  localparam int WIDTH = 9;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  logic flush;

  eq2_grad_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  eq2_grad #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit chk_en   = 1'b0;

  // Model state
  int q[$];
  bit m_valid = 1'b0;
  int m_out   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // g * f'(x) with f(x) = max(|x|,1), saturating to the 18-bit signed range
  function automatic int model_grad(input int x, input int g);
    int r;
    if (x >= 2) r = g;
    else if (x <= -2) r = -g;
    else r = 0;
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return r;
  endfunction

  // Behavioural model update on each rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_valid = 1'b0;
        m_out   = 0;
      end else begin
        bit fr, br, pu, po;
        int x;
        fr = (q.size() < DEPTH);
        br = (q.size() != 0) && (!m_valid || bus.grad_ready);
        pu = bus.fwd_valid && fr && !flush;
        po = bus.bwd_valid && br && !flush;
        if (po) begin
          x = q.pop_back();
          m_out = model_grad(x, int'(bus.bwd_g));
          m_valid = 1'b1;
        end else if (bus.grad_ready) begin
          m_valid = 1'b0;
        end
        if (pu) q.push_back(int'(bus.fwd_x));
        if (flush) q.delete();
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",      bus.count,      q.size());
      chk("fwd_ready",  bus.fwd_ready,  q.size() < DEPTH);
      chk("bwd_ready",  bus.bwd_ready,  (q.size() != 0) && (!m_valid || bus.grad_ready));
      chk("grad_valid", bus.grad_valid, m_valid);
      chk("grad_out",   bus.grad_out,   m_out);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x);
    bus.fwd_valid = 1'b1;
    bus.fwd_x     = 18'(x);
    cyc();
    bus.fwd_valid = 1'b0;
  endtask

  task automatic pop_chk(input int g, input int exp, input string name);
    bus.bwd_valid  = 1'b1;
    bus.bwd_g      = 18'(g);
    bus.grad_ready = 1'b1;
    cyc();
    bus.bwd_valid = 1'b0;
    chk(name, bus.grad_out, exp);
    chk({name, "_v"}, bus.grad_valid, 1);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.fwd_valid = 1'b0;
    bus.fwd_x = '0;
    bus.bwd_valid = 1'b0;
    bus.bwd_g = '0;
    bus.grad_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", bus.count, 0);
    chk("rst_gvalid", bus.grad_valid, 0);
    chk("rst_gout", bus.grad_out, 0);
    chk("rst_fready", bus.fwd_ready, 1);
    chk("rst_bready", bus.bwd_ready, 0);

    // Basic LIFO order
    push(5); push(0); push(-7);
    chk("lifo_cnt3", bus.count, 3);
    pop_chk(10, -10, "lifo_p1");
    pop_chk(10, 0, "lifo_p2");
    pop_chk(10, 10, "lifo_p3");
    chk("lifo_cnt0", bus.count, 0);
    cyc();
    chk("lifo_idle", bus.grad_valid, 0);

    // Kinks and saturation
    push(2); push(1); push(-1); push(-2);
    pop_chk(3, -3, "kink_m2");
    pop_chk(3, 0, "kink_m1");
    pop_chk(3, 0, "kink_p1");
    pop_chk(3, 3, "kink_p2");
    push(-100);
    pop_chk(-131072, 131071, "sat");
    cyc();

    // Full / empty
    for (int i = 0; i < DEPTH; i++) push(3 * i - 20);
    chk("full_cnt", bus.count, 16);
    chk("full_fready", bus.fwd_ready, 0);
    push(99);
    chk("full_cnt17", bus.count, 16);
    bus.bwd_valid = 1'b1;
    bus.bwd_g = 18'(1);
    bus.grad_ready = 1'b1;
    repeat (DEPTH) cyc();
    chk("drain_last", bus.grad_out, -1);
    chk("drain_cnt", bus.count, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("empty_gvalid", bus.grad_valid, 0);
      chk("empty_bready", bus.bwd_ready, 0);
    end
    bus.bwd_valid = 1'b0;

    // Backpressure
    push(7); push(8); push(9);
    bus.grad_ready = 1'b0;
    bus.bwd_valid = 1'b1;
    bus.bwd_g = 18'(2);
    cyc();
    bus.bwd_g = 18'(77);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_hold", bus.grad_out, 2);
      chk("bp_cnt", bus.count, 2);
      chk("bp_bready", bus.bwd_ready, 0);
    end
    bus.grad_ready = 1'b1;
    bus.bwd_g = 18'(5);
    #1;
    chk("bp_release", bus.bwd_ready, 1);
    cyc();
    chk("bp_p2", bus.grad_out, 5);
    bus.bwd_g = -18'sd4;
    cyc();
    chk("bp_p3", bus.grad_out, -4);
    chk("bp_cnt0", bus.count, 0);
    bus.bwd_valid = 1'b0;
    cyc();

    // Simultaneous push/pop
    push(3); push(4);
    bus.fwd_valid = 1'b1;
    bus.fwd_x = -18'sd9;
    pop_chk(1, 1, "sim_pop");
    bus.fwd_valid = 1'b0;
    chk("sim_cnt", bus.count, 2);
    pop_chk(1, -1, "sim_next");
    pop_chk(1, 1, "sim_last");
    cyc();

    // Flush with a pending output
    for (int i = 10; i < 15; i++) push(i);
    bus.grad_ready = 1'b0;
    bus.bwd_valid = 1'b1;
    bus.bwd_g = 18'(6);
    cyc();
    bus.fwd_valid = 1'b1;
    bus.fwd_x = 18'(50);
    flush = 1'b1;
    #1;
    chk("fl_fready", bus.fwd_ready, 1);
    cyc();
    flush = 1'b0;
    bus.fwd_valid = 1'b0;
    bus.bwd_valid = 1'b0;
    chk("fl_cnt", bus.count, 0);
    chk("fl_bready", bus.bwd_ready, 0);
    chk("fl_gvalid", bus.grad_valid, 1);
    chk("fl_gout", bus.grad_out, 6);
    bus.grad_ready = 1'b1;
    cyc();
    chk("fl_drained", bus.grad_valid, 0);

    // Reset mid-operation
    for (int i = 10; i < 15; i++) push(i);
    bus.grad_ready = 1'b0;
    bus.bwd_valid = 1'b1;
    bus.bwd_g = 18'(6);
    cyc();
    bus.bwd_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_gvalid", bus.grad_valid, 0);
    chk("mr_cnt", bus.count, 0);
    chk("mr_gout", bus.grad_out, 0);
    bus.grad_ready = 1'b1;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
